prod_serializer: RTL and testbench

Downstream stage of the N×N multiplier: accepts each 2·Nsize-bit product over a valid/ready handshake and shifts it out one bit per transfer on a serial link. It has one holding buffer plus the active shift register, so the multiplier can deliver the next product while the current one is still shifting. Back-to-back products stream with no idle bit between words.

---
 rtl/prod_serializer_if.sv | 25 ++
 rtl/prod_serializer.sv | 81 ++++++++
 tb/tb_prod_serializer.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prod_serializer_if.sv
// Product-to-serial link bundle: parallel product handshake in, serial bit stream out.
// master drives words and Out_en; slave is the serializer.
interface prod_serializer_if #(
    parameter int unsigned W = 100
) ();
    logic [W-1:0] R_in;
    logic         In_valid;
    logic         In_ready;
    logic         Out_en;
    logic         Sout;
    logic         Sout_valid;
    logic         Frame;
    logic         Last;
    logic         Busy;

    modport master (
        output R_in, In_valid, Out_en,
        input  In_ready, Sout, Sout_valid, Frame, Last, Busy
    );

    modport slave (
        input  R_in, In_valid, Out_en,
        output In_ready, Sout, Sout_valid, Frame, Last, Busy
    );
endinterface

// File: rtl/prod_serializer.sv
// Serializes 2*Nsize-bit multiplier products one bit per transfer, with one holding buffer
// in front of the shifter so consecutive words stream without idle bits.
module prod_serializer #(
    parameter int unsigned Nsize    = 50,
    parameter bit          MsbFirst = 1'b0
) (
    input  logic             Clk,
    input  logic             Clr_n,
    prod_serializer_if.slave ser_io
);
    localparam int unsigned W    = 2 * Nsize;
    localparam int unsigned CntW = $clog2(W);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    hold_q, hold_d;
    logic [W-1:0]    shift_q, shift_d;
    logic            hold_full_q, hold_full_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic xfer;
    logic last_xfer;
    logic accept;
    logic load;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;

        xfer      = (state_q == StShift) && ser_io.Out_en;
        last_xfer = xfer && (cnt_q == CntW'(W - 1));
        accept    = ser_io.In_valid && !hold_full_q;
        load      = hold_full_q && ((state_q == StIdle) || last_xfer);

        if (xfer) begin
            shift_d = MsbFirst ? {shift_q[W-2:0], 1'b0} : {1'b0, shift_q[W-1:1]};
            cnt_d   = cnt_q + CntW'(1);
        end
        if (last_xfer) begin
            state_d = StIdle;
        end
        if (accept) begin
            hold_d      = ser_io.R_in;
            hold_full_d = 1'b1;
        end
        // Load overrides the end-of-word return to idle, giving gapless back-to-back words.
        if (load) begin
            shift_d     = hold_q;
            cnt_d       = '0;
            state_d     = StShift;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ser_io.In_ready   = !hold_full_q;
    assign ser_io.Sout       = MsbFirst ? shift_q[W-1] : shift_q[0];
    assign ser_io.Sout_valid = (state_q == StShift);
    assign ser_io.Frame      = (state_q == StShift) && (cnt_q == '0);
    assign ser_io.Last       = (state_q == StShift) && (cnt_q == CntW'(W - 1));
    assign ser_io.Busy       = (state_q == StShift) || hold_full_q;
endmodule

// File: tb/tb_prod_serializer.sv
// Self-checking bench for prod_serializer (Nsize=4): directed timing scenarios plus a
// randomized stream compared against a queue-based model of the expected serial bits.
module tb_prod_serializer;
    localparam int unsigned N = 4;
    localparam int unsigned W = 2 * N;

    logic Clk   = 1'b0;
    logic Clr_n = 1'b0;
    always #5 Clk = ~Clk;

    prod_serializer_if #(.W(W)) ifa ();
    prod_serializer_if #(.W(W)) ifb ();

    prod_serializer #(.Nsize(N), .MsbFirst(1'b0)) dut_a (
        .Clk    (Clk),
        .Clr_n  (Clr_n),
        .ser_io (ifa)
    );

    prod_serializer #(.Nsize(N), .MsbFirst(1'b1)) dut_b (
        .Clk    (Clk),
        .Clr_n  (Clr_n),
        .ser_io (ifb)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit rand_oe = 1'b0;

    // Each entry is {bit, frame, last} for one transferred serial bit.
    logic [2:0] obs_q[$];
    logic [2:0] exp_q[$];

    function automatic void model_push(input logic [W-1:0] w, input bit msb);
        for (int i = 0; i < int'(W); i++) begin
            exp_q.push_back({(msb ? w[W-1-i] : w[i]), (i == 0), (i == int'(W) - 1)});
        end
    endfunction

    task automatic tick();
        if (rand_oe) ifa.Out_en = 1'($urandom_range(0, 1));
        if (ifa.Sout_valid && ifa.Out_en) obs_q.push_back({ifa.Sout, ifa.Frame, ifa.Last});
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        ifa.In_valid = 1'b0;
        ifb.In_valid = 1'b0;
        Clr_n = 1'b0;
        tick();
        tick();
        Clr_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send_word(input logic [W-1:0] w, output int waits, output bit ok);
        bit acc;
        ifa.R_in = w;
        ifa.In_valid = 1'b1;
        waits = 0;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            acc = ifa.In_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        ifa.In_valid = 1'b0;
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!ifa.Busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        int w;
        bit ok;
        do_reset();
        n_cmp += 6;
        if (ifa.In_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", ifa.In_ready); end
        if (ifa.Sout !== 1'b0) begin n_err++; $display("FAIL rst_sout got %b want 0", ifa.Sout); end
        if (ifa.Sout_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", ifa.Sout_valid); end
        if (ifa.Frame !== 1'b0) begin n_err++; $display("FAIL rst_frame got %b want 0", ifa.Frame); end
        if (ifa.Last !== 1'b0) begin n_err++; $display("FAIL rst_last got %b want 0", ifa.Last); end
        if (ifa.Busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", ifa.Busy); end
        // Reset in the middle of a word, then check the next word starts cleanly.
        ifa.Out_en = 1'b1;
        send_word(8'h8F, w, ok);
        tick();
        tick();
        tick();
        do_reset();
        n_cmp += 3;
        if (ifa.In_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready got %b want 1", ifa.In_ready); end
        if (ifa.Sout_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %b want 0", ifa.Sout_valid); end
        if (ifa.Busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", ifa.Busy); end
        model_push(8'h3C, 1'b0);
        send_word(8'h3C, w, ok);
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL midrst_count got %0d bits want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL midrst_bit%0d got %b want %b", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_single_word();
        logic [W-1:0] w = 8'h8F;
        do_reset();
        ifa.Out_en = 1'b1;
        ifa.R_in = w;
        ifa.In_valid = 1'b1;
        n_cmp++;
        if (ifa.In_ready !== 1'b1) begin n_err++; $display("FAIL single_ready got %b want 1", ifa.In_ready); end
        tick();
        ifa.In_valid = 1'b0;
        n_cmp += 3;
        if (ifa.Sout_valid !== 1'b0) begin n_err++; $display("FAIL single_acc_valid got %b want 0", ifa.Sout_valid); end
        if (ifa.In_ready !== 1'b0) begin n_err++; $display("FAIL single_acc_ready got %b want 0", ifa.In_ready); end
        if (ifa.Busy !== 1'b1) begin n_err++; $display("FAIL single_acc_busy got %b want 1", ifa.Busy); end
        tick();
        for (int i = 0; i < int'(W); i++) begin
            n_cmp++;
            if ({ifa.Sout_valid, ifa.Sout, ifa.Frame, ifa.Last} !== {1'b1, w[i], i == 0, i == int'(W) - 1}) begin
                n_err++;
                $display("FAIL single_bit%0d got v/s/f/l=%b want %b", i,
                         {ifa.Sout_valid, ifa.Sout, ifa.Frame, ifa.Last},
                         {1'b1, w[i], i == 0, i == int'(W) - 1});
            end
            tick();
        end
        n_cmp += 3;
        if (ifa.Sout_valid !== 1'b0) begin n_err++; $display("FAIL single_end_valid got %b want 0", ifa.Sout_valid); end
        if (ifa.Busy !== 1'b0) begin n_err++; $display("FAIL single_end_busy got %b want 0", ifa.Busy); end
        if (ifa.In_ready !== 1'b1) begin n_err++; $display("FAIL single_end_ready got %b want 1", ifa.In_ready); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w1 = 8'h8F;
        logic [W-1:0] w2 = 8'h3C;
        logic [W-1:0] cur;
        int k;
        do_reset();
        ifa.Out_en = 1'b1;
        ifa.R_in = w1;
        ifa.In_valid = 1'b1;
        tick();
        ifa.R_in = w2;
        n_cmp++;
        if (ifa.In_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full got %b want 0", ifa.In_ready); end
        tick();
        // j counts cycles from the first load; the second word is accepted at the end of j=0.
        for (int j = 0; j < 20; j++) begin
            k = j % int'(W);
            cur = (j < int'(W)) ? w1 : w2;
            n_cmp += 2;
            if ({ifa.Sout_valid, ifa.Frame, ifa.Last} !==
                {j < 16, (j < 16) && (k == 0), (j < 16) && (k == int'(W) - 1)}) begin
                n_err++;
                $display("FAIL b2b_ctl_c%0d got v/f/l=%b want %b", j,
                         {ifa.Sout_valid, ifa.Frame, ifa.Last},
                         {j < 16, (j < 16) && (k == 0), (j < 16) && (k == int'(W) - 1)});
            end
            if (ifa.In_ready !== ((j == 0) || (j >= int'(W)))) begin
                n_err++;
                $display("FAIL b2b_ready_c%0d got %b want %b", j, ifa.In_ready,
                         (j == 0) || (j >= int'(W)));
            end
            if (j < 16) begin
                n_cmp++;
                if (ifa.Sout !== cur[k]) begin
                    n_err++;
                    $display("FAIL b2b_bit_c%0d got %b want %b", j, ifa.Sout, cur[k]);
                end
            end
            tick();
            ifa.In_valid = 1'b0;
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] w = 8'hA5;
        bit ok;
        int waits;
        do_reset();
        ifa.Out_en = 1'b1;
        model_push(w, 1'b0);
        send_word(w, waits, ok);
        tick();
        tick();
        tick();
        tick();
        // Bits 0..2 have transferred; bit 3 is on the line and must hold through the stall.
        ifa.Out_en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            n_cmp++;
            if ({ifa.Sout_valid, ifa.Sout, ifa.Frame, ifa.Last} !== {1'b1, w[3], 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold_c%0d got v/s/f/l=%b want %b", s,
                         {ifa.Sout_valid, ifa.Sout, ifa.Frame, ifa.Last}, {1'b1, w[3], 1'b0, 1'b0});
            end
        end
        ifa.Out_en = 1'b1;
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL stall_count got %0d bits want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL stall_bit%0d got %b want %b", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_buffer_full();
        logic [W-1:0] words[3] = '{8'h8F, 8'h3C, 8'hA5};
        int exp_waits[3] = '{0, 1, int'(W) - 1};
        int waits;
        bit ok;
        do_reset();
        ifa.Out_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_push(words[i], 1'b0);
            send_word(words[i], waits, ok);
            n_cmp++;
            if (!ok || waits != exp_waits[i]) begin
                n_err++;
                $display("FAIL full_wait_w%0d got %0d (accepted=%b) want %0d", i, waits, ok, exp_waits[i]);
            end
        end
        drain(ok);
        n_cmp++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL full_count got %0d bits want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL full_bit%0d got %b want %b", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        int waits;
        bit ok;
        do_reset();
        rand_oe = 1'b1;
        for (int n = 0; n < 40; n++) begin
            w = W'($urandom);
            model_push(w, 1'b0);
            send_word(w, waits, ok);
            if (!ok) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_accept_w%0d got not accepted want accepted", n);
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end
        drain(ok);
        rand_oe = 1'b0;
        n_cmp++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL rand_count got %0d bits want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_cmp++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL rand_bit%0d got %b want %b", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_msb_first();
        logic [W-1:0] w = 8'h8F;
        do_reset();
        ifb.Out_en = 1'b1;
        ifb.R_in = w;
        ifb.In_valid = 1'b1;
        @(posedge Clk);
        #1;
        ifb.In_valid = 1'b0;
        @(posedge Clk);
        #1;
        for (int i = 0; i < int'(W); i++) begin
            n_cmp++;
            if ({ifb.Sout_valid, ifb.Sout, ifb.Frame, ifb.Last} !==
                {1'b1, w[W-1-i], i == 0, i == int'(W) - 1}) begin
                n_err++;
                $display("FAIL msb_bit%0d got v/s/f/l=%b want %b", i,
                         {ifb.Sout_valid, ifb.Sout, ifb.Frame, ifb.Last},
                         {1'b1, w[W-1-i], i == 0, i == int'(W) - 1});
            end
            @(posedge Clk);
            #1;
        end
        n_cmp++;
        if (ifb.Sout_valid !== 1'b0) begin n_err++; $display("FAIL msb_end_valid got %b want 0", ifb.Sout_valid); end
    endtask

    initial begin
        ifa.R_in = '0;
        ifa.In_valid = 1'b0;
        ifa.Out_en = 1'b0;
        ifb.R_in = '0;
        ifb.In_valid = 1'b0;
        ifb.Out_en = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_buffer_full();
        test_random();
        test_msb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
